revo_encoder_with_fallover: RTL and testbench
=============================================

REVO_ENCODER_WITH_FALLOVER -- requirements
Module: revo_encoder_with_fallover

Interface
REQ-001 Parameter HISTORY_WIDTH, 16, depth of the revo sample history shift register.
REQ-002 Parameter MAX_DURATION, 8, number of newest history bits in which a revo pulse must appear; legal range 1 to HISTORY_WIDTH-1.
REQ-003 Parameter WORD_WIDTH, 8, width of the serializer word.
REQ-004 Parameter PERIOD_WIDTH, 16, width of the fake-period, watchdog and revo-count counters.
REQ-005 Parameter TOLERANCE, 4, extra cycles beyond fake_period before a revo is declared missing.
REQ-006 Parameter CLOCK_WORD, 8'b11110000, idle word that encodes a plain clock edge.
REQ-007 Parameter REVO_WORD, 8'b00000000, word that encodes a revo as a suppressed clock edge.
REQ-008 Parameter CAL_WORD0, 8'b11110100, and CAL_WORD1, 8'b11110010, the calibration words.
REQ-009 Port clock, input, 1, the single clock; all logic is in this domain.
REQ-010 Port reset_n, input, 1, asynchronous active-low reset.
REQ-011 Port raw_sample, input, 1, revo level, already synchronous to clock.
REQ-012 Port mode, input, 2, operating mode: 00 REAL, 01 FAKE, 10 AUTO, 11 CAL.
REQ-013 Port cal_select, input, 1, choice of calibration word in CAL mode.
REQ-014 Port fake_period, input, PERIOD_WIDTH, fake revo period in cycles; a value of 0 disables the fake revo.
REQ-015 Port word_out, output, WORD_WIDTH, registered word for the serializer.
REQ-016 Port revo_out, output, 1, one-cycle pulse, aligned with REVO_WORD on word_out.
REQ-017 Port using_fake, output, 1, asserted when the output revo source is the fake generator.
REQ-018 Port revo_missing, output, 1, watchdog flag.
REQ-019 Port revo_count, output, PERIOD_WIDTH, count of revo_out pulses; wraps.

Function
REQ-020 On each clock edge the block shall shift raw_sample into history[0], so that older bits move toward history[HISTORY_WIDTH-1].
REQ-021 The qualify condition shall be true when history[HISTORY_WIDTH-1:MAX_DURATION] is all zero and history[MAX_DURATION-1:0] is non-zero.
REQ-022 real_revo shall be a registered one-cycle pulse on the rising edge of the qualify condition, asserted one cycle after the first 1 enters history[0].
REQ-023 A pulse longer than one cycle shall produce exactly one real_revo, and a retrigger shall require at least HISTORY_WIDTH-MAX_DURATION zero samples first.
REQ-024 The fake counter shall count 0 to fake_period-1, pulse fake_revo at the wrap, and stay at 0 with no pulses when fake_period is 0.
REQ-025 In AUTO mode a real_revo shall reset the fake counter to 0, so that the fake revo is phase-continuous on fallover.
REQ-026 The watchdog shall count cycles since the last real_revo, saturate at its maximum, and clear on a real_revo in every mode.
REQ-027 revo_missing shall assert when the watchdog exceeds fake_period+TOLERANCE, and shall clear on the cycle after a real_revo.
REQ-028 In REAL mode the output revo shall be real_revo.
REQ-029 In FAKE mode the output revo shall be fake_revo, and using_fake shall be 1.
REQ-030 In AUTO mode the output revo shall be fake_revo while revo_missing is 1, otherwise real_revo; using_fake shall equal revo_missing.
REQ-031 In AUTO mode, when real_revo and fake_revo coincide, exactly one revo shall be output and real_revo shall take precedence.
REQ-032 In CAL mode word_out shall be CAL_WORD1 if cal_select is 1, otherwise CAL_WORD0; revo_out shall be 0 and revo_count shall hold.
REQ-033 word_out shall be REVO_WORD in the cycle after an output revo, otherwise CLOCK_WORD; revo_out shall be asserted in that same cycle.
REQ-034 revo_count shall increment by one per revo_out pulse and wrap modulo 2^PERIOD_WIDTH.
REQ-035 A mode change shall take effect at the next edge and shall not clear any counter.

Reset
REQ-036 Asserting reset_n low shall immediately clear history, real_revo, the fake counter, the watchdog, revo_count, revo_out, using_fake and revo_missing.
REQ-037 While reset_n is low, word_out shall be CLOCK_WORD.
REQ-038 Reset asserted mid-pulse or mid-period shall abandon that operation, and no revo shall be emitted on release.

Structure
REQ-039 Package revo_encoder_pkg shall hold the mode encodings, the default words and the default TOLERANCE.
REQ-040 Sub-module revo_edge_detector shall contain the history register, the qualify logic and the real_revo pulse, parametrised by HISTORY_WIDTH and MAX_DURATION.

Verification
REQ-041 REAL mode: a 1-cycle high, then a 4-cycle high 20 cycles later, then 30 cycles high 20 cycles after that -> three revo_out pulses, each 2 cycles after its rising edge, each with word_out 00000000.
REQ-042 FAKE mode, fake_period 10, raw_sample 0 -> revo_out every 10 cycles, using_fake 1 and revo_count 5 after 50 cycles.
REQ-043 AUTO mode, fake_period 100, real revos every 100 cycles, then raw_sample stuck at 0 -> revo_missing asserts 105 cycles after the last real_revo, and fake revos continue in phase at 100-cycle spacing.
REQ-044 AUTO mode, real_revo coincident with a fake wrap while missing -> exactly one revo_out, revo_missing cleared the next cycle.
REQ-045 CAL mode toggling cal_select -> word_out alternates 11110100 and 11110010 with 1-cycle latency, and revo_out stays 0.
REQ-046 reset_n pulsed low mid-pulse -> all outputs reset immediately, no revo after release.

Source files
------------

// File: rtl/revo_encoder_pkg.sv
// rtl/revo_encoder_pkg.sv - shared mode encodings and default words for the revo encoder
package revo_encoder_pkg;

    typedef enum logic [1:0] {
        MODE_REAL = 2'b00,
        MODE_FAKE = 2'b01,
        MODE_AUTO = 2'b10,
        MODE_CAL  = 2'b11
    } revo_mode_e;

    localparam logic [7:0] DEFAULT_CLOCK_WORD = 8'b11110000;
    localparam logic [7:0] DEFAULT_REVO_WORD  = 8'b00000000;
    localparam logic [7:0] DEFAULT_CAL_WORD0  = 8'b11110100;
    localparam logic [7:0] DEFAULT_CAL_WORD1  = 8'b11110010;
    localparam int         DEFAULT_TOLERANCE  = 4;

endpackage

// File: rtl/revo_edge_detector.sv
// rtl/revo_edge_detector.sv - revo sample history, qualify window and one-cycle real_revo pulse
module revo_edge_detector #(
    parameter int HISTORY_WIDTH = 16,
    parameter int MAX_DURATION  = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_sample,
    output logic real_revo
);

    logic [HISTORY_WIDTH-1:0] history;
    logic                     qualify;
    logic                     qualify_q;
    // Set once a low level has been seen after reset; a level that is already
    // high on release belongs to an abandoned pulse and must not be detected.
    logic                     armed;

    // A revo is a fresh burst of ones confined to the newest MAX_DURATION samples.
    assign qualify = (history[HISTORY_WIDTH-1:MAX_DURATION] == '0) &&
                     (history[MAX_DURATION-1:0] != '0);

    // Shift the history and register the rising edge of the qualify window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            history   <= '0;
            qualify_q <= 1'b0;
            real_revo <= 1'b0;
            armed     <= 1'b0;
        end else begin
            history   <= {history[HISTORY_WIDTH-2:0], raw_sample & armed};
            qualify_q <= qualify;
            real_revo <= qualify & ~qualify_q;
            armed     <= armed | ~raw_sample;
        end
    end

endmodule

// File: rtl/revo_encoder_with_fallover.sv
// rtl/revo_encoder_with_fallover.sv - revo encoder with fake-revo generator, watchdog and fallover
module revo_encoder_with_fallover
    import revo_encoder_pkg::*;
#(
    parameter int                    HISTORY_WIDTH = 16,
    parameter int                    MAX_DURATION  = 8,
    parameter int                    WORD_WIDTH    = 8,
    parameter int                    PERIOD_WIDTH  = 16,
    parameter int                    TOLERANCE     = DEFAULT_TOLERANCE,
    parameter logic [WORD_WIDTH-1:0] CLOCK_WORD    = DEFAULT_CLOCK_WORD,
    parameter logic [WORD_WIDTH-1:0] REVO_WORD     = DEFAULT_REVO_WORD,
    parameter logic [WORD_WIDTH-1:0] CAL_WORD0     = DEFAULT_CAL_WORD0,
    parameter logic [WORD_WIDTH-1:0] CAL_WORD1     = DEFAULT_CAL_WORD1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    raw_sample,
    input  logic [1:0]              mode,
    input  logic                    cal_select,
    input  logic [PERIOD_WIDTH-1:0] fake_period,
    output logic [WORD_WIDTH-1:0]   word_out,
    output logic                    revo_out,
    output logic                    using_fake,
    output logic                    revo_missing,
    output logic [PERIOD_WIDTH-1:0] revo_count
);

    localparam logic [PERIOD_WIDTH-1:0] P_ONE  = 1;
    localparam logic [PERIOD_WIDTH-1:0] WD_MAX = '1;

    revo_mode_e              mode_e;
    logic                    real_revo;
    logic [PERIOD_WIDTH-1:0] fake_cnt;
    logic [PERIOD_WIDTH-1:0] fake_last;
    logic                    fake_enable;
    logic                    fake_revo;
    logic [PERIOD_WIDTH-1:0] watchdog;
    logic [PERIOD_WIDTH:0]   missing_thresh;
    logic                    out_revo;
    logic                    fake_source;

    assign mode_e = revo_mode_e'(mode);

    revo_edge_detector #(
        .HISTORY_WIDTH (HISTORY_WIDTH),
        .MAX_DURATION  (MAX_DURATION)
    ) u_edge_detector (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_sample (raw_sample),
        .real_revo  (real_revo)
    );

    // Fake revo fires on the last count; >= keeps the counter bounded if fake_period shrinks.
    assign fake_enable = (fake_period != '0);
    assign fake_last   = fake_period - P_ONE;
    assign fake_revo   = fake_enable && (fake_cnt >= fake_last);

    // Fake period counter; a real revo in AUTO re-phases it so fallover is seamless.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fake_cnt <= '0;
        end else if (!fake_enable || fake_revo || (mode_e == MODE_AUTO && real_revo)) begin
            fake_cnt <= '0;
        end else begin
            fake_cnt <= fake_cnt + P_ONE;
        end
    end

    // Watchdog holds the number of cycles elapsed since the last real revo (1 in the
    // cycle right after it), saturating so a long outage never looks like a fresh revo.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            watchdog <= '0;
        end else if (real_revo) begin
            watchdog <= P_ONE;
        end else if (watchdog != WD_MAX) begin
            watchdog <= watchdog + P_ONE;
        end
    end

    assign missing_thresh = {1'b0, fake_period} + (PERIOD_WIDTH+1)'(TOLERANCE);
    assign revo_missing   = ({1'b0, watchdog} > missing_thresh);

    // Select the revo source for this cycle; a coincident real and fake revo yields one.
    always_comb begin
        out_revo    = 1'b0;
        fake_source = 1'b0;
        case (mode_e)
            MODE_REAL: out_revo = real_revo;
            MODE_FAKE: begin
                out_revo    = fake_revo;
                fake_source = 1'b1;
            end
            MODE_AUTO: begin
                out_revo    = real_revo | (revo_missing & fake_revo);
                fake_source = revo_missing;
            end
            default: begin
                out_revo    = 1'b0;
                fake_source = 1'b0;
            end
        endcase
    end

    // Register the serializer word, the revo strobe and the revo counter together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_out   <= CLOCK_WORD;
            revo_out   <= 1'b0;
            using_fake <= 1'b0;
            revo_count <= '0;
        end else begin
            revo_out   <= out_revo;
            using_fake <= fake_source;
            if (out_revo) begin
                revo_count <= revo_count + P_ONE;
            end
            if (mode_e == MODE_CAL) begin
                word_out <= cal_select ? CAL_WORD1 : CAL_WORD0;
            end else if (out_revo) begin
                word_out <= REVO_WORD;
            end else begin
                word_out <= CLOCK_WORD;
            end
        end
    end

endmodule

// File: tb/tb_revo_encoder_with_fallover.sv
// tb/tb_revo_encoder_with_fallover.sv - directed self-checking bench for revo_encoder_with_fallover
module tb_revo_encoder_with_fallover;

    localparam logic [7:0] CLK_W  = 8'b11110000;
    localparam logic [7:0] REVO_W = 8'b00000000;
    localparam logic [7:0] CAL0_W = 8'b11110100;
    localparam logic [7:0] CAL1_W = 8'b11110010;
    localparam logic [1:0] M_REAL = 2'b00;
    localparam logic [1:0] M_FAKE = 2'b01;
    localparam logic [1:0] M_AUTO = 2'b10;
    localparam logic [1:0] M_CAL  = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        raw_sample;
    logic [1:0]  mode;
    logic        cal_select;
    logic [15:0] fake_period;
    logic [7:0]  word_out;
    logic        revo_out;
    logic        using_fake;
    logic        revo_missing;
    logic [15:0] revo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit word_chk = 1'b0;
    int revo_log[$];
    int exp_log[$];

    typedef struct {
        logic [1:0] mode;
        logic       cal;
        logic       raw;
        logic [7:0] exp_word;
        logic       exp_revo;
    } vec_t;

    vec_t vecs[10];

    always #5 clock = ~clock;

    revo_encoder_with_fallover dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .raw_sample   (raw_sample),
        .mode         (mode),
        .cal_select   (cal_select),
        .fake_period  (fake_period),
        .word_out     (word_out),
        .revo_out     (revo_out),
        .using_fake   (using_fake),
        .revo_missing (revo_missing),
        .revo_count   (revo_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (revo_out === 1'b1) revo_log.push_back(cyc);
        if (word_chk) check("word_vs_revo", 32'(word_out), revo_out ? 32'(REVO_W) : 32'(CLK_W));
    endtask

    task automatic check_log(input string name);
        check({name, "_num"}, 32'(revo_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < revo_log.size(); i++)
            check(name, 32'(revo_log[i]), 32'(exp_log[i]));
    endtask

    initial begin
        int base;
        int cnt0;
        int s_k;
        int miss_at;

        vecs[0] = '{M_REAL, 1'b0, 1'b0, CLK_W,  1'b0};
        vecs[1] = '{M_REAL, 1'b0, 1'b1, CLK_W,  1'b0};
        vecs[2] = '{M_REAL, 1'b0, 1'b0, CLK_W,  1'b0};
        vecs[3] = '{M_REAL, 1'b0, 1'b0, REVO_W, 1'b1};
        vecs[4] = '{M_REAL, 1'b0, 1'b0, CLK_W,  1'b0};
        vecs[5] = '{M_CAL,  1'b0, 1'b0, CAL0_W, 1'b0};
        vecs[6] = '{M_CAL,  1'b1, 1'b0, CAL1_W, 1'b0};
        vecs[7] = '{M_CAL,  1'b0, 1'b0, CAL0_W, 1'b0};
        vecs[8] = '{M_CAL,  1'b1, 1'b0, CAL1_W, 1'b0};
        vecs[9] = '{M_REAL, 1'b0, 1'b0, CLK_W,  1'b0};

        reset_n     = 1'b0;
        raw_sample  = 1'b0;
        mode        = M_REAL;
        cal_select  = 1'b0;
        fake_period = 16'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_word",    32'(word_out),     32'(CLK_W));
        check("rst_revo",    32'(revo_out),     32'd0);
        check("rst_count",   32'(revo_count),   32'd0);
        check("rst_missing", 32'(revo_missing), 32'd0);
        check("rst_fake",    32'(using_fake),   32'd0);
        reset_n = 1'b1;

        // Single-sample revo, then CAL word toggling.
        for (int i = 0; i < 10; i++) begin
            mode       = vecs[i].mode;
            cal_select = vecs[i].cal;
            raw_sample = vecs[i].raw;
            step();
            check($sformatf("vec%0d_word", i), 32'(word_out), 32'(vecs[i].exp_word));
            check($sformatf("vec%0d_revo", i), 32'(revo_out), 32'(vecs[i].exp_revo));
        end
        check("count_after_table", 32'(revo_count), 32'd1);

        // REAL: 1-cycle, 4-cycle and 30-cycle pulses each give one revo two cycles later.
        word_chk = 1'b1;
        mode = M_REAL;
        raw_sample = 1'b0;
        repeat (20) step();
        revo_log.delete(); exp_log.delete();
        cnt0 = int'(revo_count);
        exp_log.push_back(cyc + 3); raw_sample = 1'b1; step();            raw_sample = 1'b0; repeat (20) step();
        exp_log.push_back(cyc + 3); raw_sample = 1'b1; repeat (4) step(); raw_sample = 1'b0; repeat (20) step();
        exp_log.push_back(cyc + 3); raw_sample = 1'b1; repeat (30) step(); raw_sample = 1'b0; repeat (30) step();
        check_log("real_pulses");
        check("real_count", 32'(revo_count), 32'(cnt0 + 3));

        // FAKE: period 10 -> revo every 10 cycles.
        revo_log.delete(); exp_log.delete();
        base = cyc;
        cnt0 = int'(revo_count);
        mode = M_FAKE;
        fake_period = 16'd10;
        repeat (50) step();
        for (int k = 1; k <= 5; k++) exp_log.push_back(base + 10 * k);
        check_log("fake_pulses");
        check("fake_count", 32'(revo_count), 32'(cnt0 + 5));
        check("fake_using", 32'(using_fake), 32'd1);

        // AUTO: real revos every 100 cycles, then the source goes quiet.
        mode = M_AUTO;
        fake_period = 16'd100;
        raw_sample = 1'b1; step(); raw_sample = 1'b0; repeat (99) step();
        revo_log.delete(); exp_log.delete();
        s_k = 0;
        for (int k = 1; k <= 3; k++) begin
            raw_sample = 1'b1;
            step();
            s_k = cyc;
            exp_log.push_back(s_k + 2);
            raw_sample = 1'b0;
            repeat (99) step();
        end
        miss_at = -1;
        repeat (300) begin
            step();
            if (miss_at < 0 && revo_missing === 1'b1) miss_at = cyc;
        end
        exp_log.push_back(s_k + 202);
        exp_log.push_back(s_k + 302);
        check_log("auto_pulses");
        check("auto_missing_at", 32'(miss_at), 32'(s_k + 106));
        check("auto_using", 32'(using_fake), 32'd1);

        // AUTO: real revo coinciding with a fake wrap while missing -> one revo.
        revo_log.delete();
        cnt0 = int'(revo_count);
        raw_sample = 1'b1; step(); raw_sample = 1'b0;
        step();
        check("coin_missing_before", 32'(revo_missing), 32'd1);
        step();
        check("coin_revo",          32'(revo_out),     32'd1);
        check("coin_missing_after", 32'(revo_missing), 32'd0);
        repeat (20) step();
        check("coin_num",   32'(revo_log.size()), 32'd1);
        check("coin_count", 32'(revo_count),      32'(cnt0 + 1));
        check("coin_using", 32'(using_fake),      32'd0);

        // Reset mid-pulse: outputs clear at once, nothing emitted after release.
        mode = M_REAL;
        fake_period = 16'd0;
        repeat (20) step();
        raw_sample = 1'b1;
        repeat (3) step();
        check("pre_rst_revo", 32'(revo_out), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_revo",    32'(revo_out),     32'd0);
        check("mid_rst_word",    32'(word_out),     32'(CLK_W));
        check("mid_rst_count",   32'(revo_count),   32'd0);
        check("mid_rst_missing", 32'(revo_missing), 32'd0);
        check("mid_rst_using",   32'(using_fake),   32'd0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        revo_log.delete();
        repeat (3) step();
        raw_sample = 1'b0;
        repeat (25) step();
        check("post_rst_num",   32'(revo_log.size()), 32'd0);
        check("post_rst_count", 32'(revo_count),      32'd0);

        // FAKE with period 0 never pulses.
        revo_log.delete();
        mode = M_FAKE;
        repeat (30) step();
        check("fake0_num",   32'(revo_log.size()), 32'd0);
        check("fake0_using", 32'(using_fake),      32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
